// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg
//   Shared definitions for the two-input gate-block self-test:
//   FSM state type, bit positions of the seven gate outputs inside the
//   response vector, and the golden truth function for those outputs.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int Y_AND  = 0;
  localparam int Y_NAND = 1;
  localparam int Y_OR   = 2;
  localparam int Y_NOR  = 3;
  localparam int Y_NOT  = 4;
  localparam int Y_XOR  = 5;
  localparam int Y_XNOR = 6;
  localparam int NUM_Y  = 7;

  // Expected gate-block response for inputs a,b; bit order matches y_in.
  function automatic logic [NUM_Y-1:0] gate_golden(input logic a, input logic b);
    logic [NUM_Y-1:0] y;
    y         = {NUM_Y{1'b0}};
    y[Y_AND]  = a & b;
    y[Y_NAND] = ~(a & b);
    y[Y_OR]   = a | b;
    y[Y_NOR]  = ~(a | b);
    y[Y_NOT]  = ~a;
    y[Y_XOR]  = a ^ b;
    y[Y_XNOR] = ~(a ^ b);
    return y;
  endfunction

endpackage

// File: rtl/gate_golden_model.sv
// gate_golden_model
//   Combinational reference model of the two-input gate block.
//   Ports:
//     i_a, i_b     gate inputs
//     o_expected   expected {xnor,xor,not,nor,or,nand,and}; bit0 = and
module gate_golden_model
  import gate_sweep_pkg::*;
(
  input  logic             i_a,
  input  logic             i_b,
  output logic [NUM_Y-1:0] o_expected
);

  assign o_expected = gate_golden(i_a, i_b);

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//   Drives the gate block through the 00,01,10,11 truth-table sweep, holding
//   each vector DWELL_CYCLES clocks, and compares the gate outputs against the
//   golden model in the last clock of every vector. Reports a sticky per-output
//   mismatch mask, a saturating count of mismatching vectors and pass/done.
//   Ports:
//     clk, rst_n     clock (rising edge), synchronous active-low reset
//     start          one-cycle run request, honoured only in IDLE or DONE
//     a_out, b_out   registered stimulus to the gate block
//     y_in           gate outputs {xnor,xor,not,nor,or,nand,and}
//     busy, done     run in progress / run finished (held until restart)
//     pass           valid with done: no vector mismatched
//     vec_idx        current vector {a,b}
//     err_mask       sticky per-output mismatch flags
//     err_count      mismatching vectors, saturating at 2**ERR_W-1
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int DWELL_CYCLES = 10,
  parameter int ROUNDS       = 1,
  parameter int ERR_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic [NUM_Y-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       vec_idx,
  output logic [NUM_Y-1:0] err_mask,
  output logic [ERR_W-1:0] err_count
);

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL_CYCLES - 2);
  localparam logic [RW-1:0]    ROUND_LAST = RW'(ROUNDS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

  state_e           r_state;
  logic [DW-1:0]    r_dwell;
  logic [RW-1:0]    r_round;
  logic [1:0]       r_vec;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [NUM_Y-1:0] r_err_mask;
  logic [ERR_W-1:0] r_err_count;

  logic [NUM_Y-1:0] w_expected;
  logic [NUM_Y-1:0] w_diff;
  logic [ERR_W-1:0] w_err_count_next;
  logic             w_last_vec;

  // The stimulus is the vector index itself, so a/b are register bits.
  assign a_out     = r_vec[1];
  assign b_out     = r_vec[0];
  assign vec_idx   = r_vec;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_mask  = r_err_mask;
  assign err_count = r_err_count;

  gate_golden_model u_golden (
    .i_a        (r_vec[1]),
    .i_b        (r_vec[0]),
    .o_expected (w_expected)
  );

  assign w_diff     = y_in ^ w_expected;
  assign w_last_vec = (r_vec == 2'd3) && (r_round == ROUND_LAST);

  // Error count after the current clock; it only moves on a mismatching sample.
  always_comb begin
    w_err_count_next = r_err_count;
    if ((r_state == SAMPLE) && (|w_diff) && (r_err_count != ERR_MAX)) begin
      w_err_count_next = r_err_count + ERR_W'(1);
    end else begin
      w_err_count_next = r_err_count;
    end
  end

  // Sweep FSM with dwell/vector/round counters and result accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_dwell     <= '0;
      r_round     <= '0;
      r_vec       <= 2'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_mask  <= '0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          // DONE keeps its results and stimulus (11) until a new start.
          if (start) begin
            r_state     <= DRIVE;
            r_dwell     <= '0;
            r_round     <= '0;
            r_vec       <= 2'd0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_mask  <= '0;
            r_err_count <= '0;
          end
        end
        DRIVE: begin
          // DWELL_CYCLES-1 drive clocks, then one sample clock.
          if (r_dwell == DWELL_LAST) begin
            r_state <= SAMPLE;
          end else begin
            r_dwell <= r_dwell + DW'(1);
          end
        end
        SAMPLE: begin
          r_err_mask  <= r_err_mask | w_diff;
          r_err_count <= w_err_count_next;
          if (w_last_vec) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_count_next == '0);
          end else begin
            r_state <= DRIVE;
            r_dwell <= '0;
            r_vec   <= r_vec + 2'd1;
            if (r_vec == 2'd3) begin
              r_round <= r_round + RW'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker
//   Directed bench: a behavioural gate block (truth table with selectable
//   faults and an optional one-cycle settle glitch) sits in the loop of two
//   checker instances, one with ROUNDS=1 and one with ROUNDS=5.
module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start5 = 1'b0;
  int         mode = 0;        // 0 good, 1 xor stuck-at-0, 2 all inverted
  logic       glitch_en = 1'b0;

  logic       a_out, b_out, busy, done, pass;
  logic [1:0] vec_idx;
  logic [6:0] y_in, err_mask;
  logic [3:0] err_count;
  logic [1:0] prev_ab = 2'b00;

  logic       a5, b5, busy5, done5, pass5;
  logic [1:0] vec5;
  logic [6:0] y5, mask5;
  logic [3:0] count5;
  logic [1:0] prev_ab5 = 2'b00;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Gate block: hand-written truth table {xnor,xor,not,nor,or,nand,and}.
  function automatic logic [6:0] gate_block(input logic a, input logic b, input int m,
                                            input logic glitch);
    logic [1:0] ab;
    logic [6:0] y;
    ab = {a, b};
    case (ab)
      2'b00:   y = 7'b1011010;
      2'b01:   y = 7'b0110110;
      2'b10:   y = 7'b0100110;
      default: y = 7'b1000101;
    endcase
    if (m == 1) y[5] = 1'b0;
    else if (m == 2) y = ~y;
    if (glitch) y = ~y;
    return y;
  endfunction

  always @(posedge clk) prev_ab  <= {a_out, b_out};
  always @(posedge clk) prev_ab5 <= {a5, b5};

  assign y_in = gate_block(a_out, b_out, mode, glitch_en && ({a_out, b_out} != prev_ab));
  assign y5   = gate_block(a5, b5, mode, glitch_en && ({a5, b5} != prev_ab5));

  gate_sweep_checker #(.DWELL_CYCLES(10), .ROUNDS(1), .ERR_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_out(a_out), .b_out(b_out),
    .y_in(y_in), .busy(busy), .done(done), .pass(pass), .vec_idx(vec_idx),
    .err_mask(err_mask), .err_count(err_count)
  );

  gate_sweep_checker #(.DWELL_CYCLES(10), .ROUNDS(5), .ERR_W(4)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .a_out(a5), .b_out(b5),
    .y_in(y5), .busy(busy5), .done(done5), .pass(pass5), .vec_idx(vec5),
    .err_mask(mask5), .err_count(count5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start is sampled at the next edge (t); returns at t+#1, i.e. the first run cycle.
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = 0;
    while (!done && lat < limit) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++; if ({a_out, b_out} !== 2'b00) begin n_bad++; $display("FAIL reset_ab got=%b exp=00", {a_out, b_out}); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    n_vec++; if (pass !== 1'b0) begin n_bad++; $display("FAIL reset_pass got=%b exp=0", pass); end
    n_vec++; if (vec_idx !== 2'd0) begin n_bad++; $display("FAIL reset_vec got=%0d exp=0", vec_idx); end
    n_vec++; if (err_mask !== 7'h00) begin n_bad++; $display("FAIL reset_mask got=%h exp=00", err_mask); end
    n_vec++; if (err_count !== 4'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", err_count); end
    rst_n = 1'b1;
    tick();
  endtask

  // Good gate block with a settle glitch after each vector change.
  task automatic test_clean_sweep();
    logic [1:0] v;
    mode = 0;
    glitch_en = 1'b1;
    pulse_start();
    for (int k = 0; k < 40; k++) begin
      v = 2'(k / 10);
      n_vec++;
      if ({busy, done, a_out, b_out, vec_idx} !== {1'b1, 1'b0, v, v}) begin
        n_bad++;
        $display("FAIL sweep_cycle%0d got busy,done,ab,vec=%b exp=%b", k,
                 {busy, done, a_out, b_out, vec_idx}, {1'b1, 1'b0, v, v});
      end
      tick();
    end
    n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL sweep_done_t41 got=%b exp=1", done); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sweep_busy got=%b exp=0", busy); end
    n_vec++; if (pass !== 1'b1) begin n_bad++; $display("FAIL sweep_pass got=%b exp=1", pass); end
    n_vec++; if (err_mask !== 7'h00) begin n_bad++; $display("FAIL sweep_mask got=%h exp=00", err_mask); end
    n_vec++; if (err_count !== 4'd0) begin n_bad++; $display("FAIL sweep_count got=%0d exp=0", err_count); end
    tick();
    tick();
    n_vec++;
    if ({done, a_out, b_out, vec_idx} !== 5'b1_11_11) begin
      n_bad++;
      $display("FAIL sweep_hold got done,ab,vec=%b exp=11111", {done, a_out, b_out, vec_idx});
    end
    glitch_en = 1'b0;
  endtask

  task automatic test_xor_stuck();
    int lat;
    mode = 1;
    pulse_start();
    wait_done(100, lat);
    n_vec++; if (lat != 40) begin n_bad++; $display("FAIL xor_latency got=%0d exp=40", lat); end
    n_vec++; if (err_mask !== 7'b0100000) begin n_bad++; $display("FAIL xor_mask got=%b exp=0100000", err_mask); end
    n_vec++; if (err_count !== 4'd2) begin n_bad++; $display("FAIL xor_count got=%0d exp=2", err_count); end
    n_vec++; if (pass !== 1'b0) begin n_bad++; $display("FAIL xor_pass got=%b exp=0", pass); end
  endtask

  // 5 rounds of 4 fully inverted vectors: 20 bad vectors, count stops at 15.
  task automatic test_saturate();
    int lat;
    mode = 2;
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    lat = 0;
    while (!done5 && lat < 400) begin
      tick();
      lat++;
    end
    n_vec++; if (lat != 200) begin n_bad++; $display("FAIL sat_latency got=%0d exp=200", lat); end
    n_vec++; if (mask5 !== 7'h7F) begin n_bad++; $display("FAIL sat_mask got=%h exp=7f", mask5); end
    n_vec++; if (count5 !== 4'd15) begin n_bad++; $display("FAIL sat_count got=%0d exp=15", count5); end
    n_vec++; if (pass5 !== 1'b0) begin n_bad++; $display("FAIL sat_pass got=%b exp=0", pass5); end
  endtask

  task automatic test_start_ignored();
    int lat;
    mode = 0;
    pulse_start();
    for (int k = 0; k < 25; k++) tick();
    pulse_start();
    n_vec++; if (vec_idx !== 2'd2) begin n_bad++; $display("FAIL ignore_vec got=%0d exp=2", vec_idx); end
    wait_done(100, lat);
    n_vec++; if (lat != 14) begin n_bad++; $display("FAIL ignore_latency got=%0d exp=14", lat); end
    n_vec++; if (pass !== 1'b1) begin n_bad++; $display("FAIL ignore_pass got=%b exp=1", pass); end
  endtask

  task automatic test_reset_midrun();
    logic seen;
    pulse_start();
    for (int k = 0; k < 25; k++) tick();
    rst_n = 1'b0;
    tick();
    n_vec++;
    if ({a_out, b_out, busy, done, pass, vec_idx} !== 7'b0) begin
      n_bad++;
      $display("FAIL midreset_outs got ab,busy,done,pass,vec=%b exp=0000000",
               {a_out, b_out, busy, done, pass, vec_idx});
    end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midreset_no_done got=%b exp=0", seen); end
  endtask

  task automatic test_restart_from_done();
    int lat;
    mode = 1;
    pulse_start();
    wait_done(100, lat);
    mode = 0;
    pulse_start();
    n_vec++;
    if ({done, busy, err_mask, err_count, vec_idx, a_out, b_out} !== {1'b0, 1'b1, 7'h00, 4'd0, 2'd0, 2'b00}) begin
      n_bad++;
      $display("FAIL restart_clear got done=%b busy=%b mask=%h count=%0d vec=%0d ab=%b exp done=0 busy=1 rest 0",
               done, busy, err_mask, err_count, vec_idx, {a_out, b_out});
    end
    for (int k = 0; k < 10; k++) tick();
    n_vec++; if (vec_idx !== 2'd1) begin n_bad++; $display("FAIL restart_vec1 got=%0d exp=1", vec_idx); end
    wait_done(100, lat);
    n_vec++; if (lat != 30) begin n_bad++; $display("FAIL restart_latency got=%0d exp=30", lat); end
    n_vec++; if (pass !== 1'b1) begin n_bad++; $display("FAIL restart_pass got=%b exp=1", pass); end
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_xor_stuck();
    test_saturate();
    test_start_ignored();
    test_reset_midrun();
    test_restart_from_done();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
